// File: rtl/poly_ram_streamer_if.sv
// Bundle of the streamer's bus-level signals.
//   RAM read side : r1_en/r1_addr/r2_en/r2_addr out of the streamer,
//                   d1_in/d2_in back from the RAM.
//   Pair stream   : out_valid/out_data/out_last out of the streamer,
//                   out_ready back from the consumer.
// Stream handshake: a pair transfers on a rising clock edge where out_valid
// and out_ready are both high; while out_valid is high and out_ready is low,
// out_data and out_last hold their values. out_valid never waits on out_ready.
// The master modport is the streamer; the slave modport is the RAM and the
// consumer seen together.
interface poly_ram_streamer_if;
  logic        r1_en;
  logic [15:0] r1_addr;
  logic        r2_en;
  logic [15:0] r2_addr;
  logic [15:0] d1_in;
  logic [15:0] d2_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output r1_en, r1_addr, r2_en, r2_addr,
    input  d1_in, d2_in,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  r1_en, r1_addr, r2_en, r2_addr,
    output d1_in, d2_in,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/poly_ram_streamer.sv
// Read-side initiator for the dual-port polynomial RAM.
// A start pulse in IDLE sweeps all DEPTH coefficients, two per cycle, and
// streams them out as pairs {coef[2k+1], coef[2k]}.
// Ports:
//   clk       - clock, all logic on posedge
//   reset     - asynchronous active-high reset
//   start     - begin one sweep (only honoured in IDLE)
//   bus       - RAM read ports and output pair stream (master side)
//   busy      - high from the cycle after start until the done cycle inclusive
//   done      - one-cycle pulse after the final pair has been handshaken
//   fsm_state - current FSM state, for observation
module poly_ram_streamer #(
  parameter int DEPTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  poly_ram_streamer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [1:0]          fsm_state
);

  localparam int NPAIRS = DEPTH / 2;
  localparam int KW     = $clog2(NPAIRS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;          // pairs issued so far this sweep
  logic [15:0]     r1_addr_q, r2_addr_q;
  logic            inflight_q;        // a read was issued last cycle
  logic            inflight_last_q;   // that read was for the final pair

  // Two-entry pair FIFO; each entry carries its own last flag.
  logic [31:0]     fifo_data_q [2];
  logic [1:0]      fifo_last_q;
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;

  logic            pop, push, credit_ok, issue, last_issue;
  logic [15:0]     addr_even, addr_odd;

  assign pop  = (count_q != 2'd0) && bus.out_ready;
  assign push = inflight_q;

  // Data already buffered or on its way, less the entry leaving this cycle,
  // must leave room for one more pair; this caps the FIFO at two entries.
  assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});

  assign issue      = (state_q == S_RUN) && (k_q < KW'(NPAIRS)) && credit_ok;
  assign last_issue = (k_q == KW'(NPAIRS - 1));

  assign addr_even = 16'({k_q, 1'b0});
  assign addr_odd  = 16'({k_q, 1'b1});

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          k_d = k_q + KW'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final pair leaving the FIFO ends the sweep; the empty/idle
        // test covers the case where it has already gone.
        if ((pop && fifo_last_q[rd_ptr_q]) || (count_q == 2'd0 && !inflight_q))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      k_q             <= '0;
      r1_addr_q       <= '0;
      r2_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      inflight_q <= issue;
      if (issue) begin
        r1_addr_q       <= addr_even;
        r2_addr_q       <= addr_odd;
        inflight_last_q <= last_issue;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= {bus.d2_in, bus.d1_in};
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs: enables follow the issue decision within the cycle, addresses
  // show the current pair while issuing and otherwise hold the last one.
  assign bus.r1_en     = issue;
  assign bus.r2_en     = issue;
  assign bus.r1_addr   = issue ? addr_even : r1_addr_q;
  assign bus.r2_addr   = issue ? addr_odd  : r2_addr_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_last  = (count_q != 2'd0) && fifo_last_q[rd_ptr_q];

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fsm_state = state_q;

endmodule
